csa_operand_packer: RTL

- Producer end of the carry-save adder's flat operand bus: accepts a stream of W-bit operands over a valid/ready handshake and assembles N of them into one packed W*N vector for the CSA.
- Sits between the CNN pixel/weight-product stream and the carry_save_adder input `a`.
- Two-deep buffering (fill register plus output register) sustains one operand per cycle while the consumer applies backpressure.

---
 rtl/csa_operand_packer_if.sv | 37 +++
 rtl/csa_operand_packer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/csa_operand_packer_if.sv
// Operand-in / packed-vector-out bus for csa_operand_packer.
// CSA_REF_SUM_EN adds out_ref_sum alongside out_data.
interface csa_operand_packer_if #(
    parameter int N = 9,
    parameter int E = 3,
    parameter int W = 4
);
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [W*N-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_partial;
`ifdef CSA_REF_SUM_EN
    logic [W+E:0]   out_ref_sum;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_partial, out_ref_sum
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_partial, out_ref_sum
    );
`else
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_partial
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_partial
    );
`endif
endinterface

// File: rtl/csa_operand_packer.sv
// Packs N W-bit operands into one W*N vector for the CSA, fill + output register.
// Optional macro CSA_REF_SUM_EN adds a reference sum aligned with out_data.
//
// state   | meaning
// ST_FILL | fill register accepting operands
// ST_HOLD | fill vector closed, waiting for the output register to free up
module csa_operand_packer #(
    parameter int N = 9,
    parameter int E = 3,
    parameter int W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    csa_operand_packer_if.slave  bus
);
    localparam int CNT_W = $clog2(N);

    typedef enum logic {ST_FILL, ST_HOLD} state_t;

    state_t         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [W*N-1:0] r_fill;
    logic           r_fill_partial;
    logic [W*N-1:0] r_out;
    logic           r_out_valid;
    logic           r_out_partial;
    logic           r_in_ready;

    logic [W*N-1:0] w_fill_vec;
    logic           w_accept;
    logic           w_consume;
    logic           w_out_free;
    logic           w_full_slot;
    logic           w_close;
    logic           w_hold_next;

    always_comb begin
        w_fill_vec = r_fill;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_fill_vec[k*W +: W] = bus.in_data;
            end
        end
    end

    assign w_accept    = bus.in_valid && r_in_ready;
    assign w_consume   = r_out_valid && bus.out_ready;
    assign w_out_free  = !r_out_valid || w_consume;
    assign w_full_slot = (r_cnt == CNT_W'(N-1));
    assign w_close     = w_accept && (w_full_slot || bus.in_last);
    // in_ready is registered, so it must already reflect a stall created on this edge
    assign w_hold_next = (r_state == ST_HOLD) ? !w_out_free : (w_close && !w_out_free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_FILL;
            r_cnt          <= '0;
            r_fill         <= '0;
            r_fill_partial <= 1'b0;
            r_out          <= '0;
            r_out_valid    <= 1'b0;
            r_out_partial  <= 1'b0;
            r_in_ready     <= 1'b0;
        end else begin
            r_in_ready <= !w_hold_next;
            if (w_consume) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                ST_HOLD: begin
                    if (w_out_free) begin
                        r_out         <= r_fill;
                        r_out_partial <= r_fill_partial;
                        r_out_valid   <= 1'b1;
                        r_fill        <= '0;
                        r_state       <= ST_FILL;
                    end
                end
                default: begin
                    if (w_close) begin
                        r_cnt <= '0;
                        if (w_out_free) begin
                            r_out         <= w_fill_vec;
                            r_out_partial <= !w_full_slot;
                            r_out_valid   <= 1'b1;
                            r_fill        <= '0;
                        end else begin
                            r_fill         <= w_fill_vec;
                            r_fill_partial <= !w_full_slot;
                            r_state        <= ST_HOLD;
                        end
                    end else if (w_accept) begin
                        r_fill <= w_fill_vec;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_data    = r_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_partial = r_out_partial;

`ifdef CSA_REF_SUM_EN
    localparam int SUM_W = W + E + 1;

    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_out_sum;
    logic [SUM_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + SUM_W'(bus.in_data);

    // Mirrors the fill/output register moves above so the sum tracks its vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_out_sum <= '0;
        end else if (r_state == ST_HOLD) begin
            if (w_out_free) begin
                r_out_sum <= r_acc;
                r_acc     <= '0;
            end
        end else if (w_close) begin
            if (w_out_free) begin
                r_out_sum <= w_acc_next;
                r_acc     <= '0;
            end else begin
                r_acc <= w_acc_next;
            end
        end else if (w_accept) begin
            r_acc <= w_acc_next;
        end
    end

    assign bus.out_ref_sum = r_out_sum;
`endif
endmodule
